tower_su3_scheduler: RTL

- Shares one SU(3) rotation core (one operation in flight) between NREQ requesters.
- Round-robin arbitrates requests, latches operands, pulses the core start and waits for the core result.
- Returns the result, tagged with the requester index, on a single ready/valid response channel.
- Sits in the tower layer, between the requesters and the SU(3) rotation datapath.

---
 rtl/tower_su3_scheduler.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/tower_su3_scheduler.sv
// tower_su3_scheduler: round-robin arbiter that shares one SU(3) rotation core
// between NREQ requesters and returns each result tagged with the requester id.
// Optional WAIT-state watchdog: define TOWER_SU3_SCHED_TIMEOUT_EN.
module tower_su3_scheduler #(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned IDW            = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid_i,
  output logic [NREQ-1:0]     req_ready_o,
  input  logic [3*NREQ-1:0]   req_axis_i,
  input  logic [32*NREQ-1:0]  req_angle_i,
  input  logic [96*NREQ-1:0]  req_qutrit_i,
  output logic                core_start_o,
  output logic [2:0]          core_axis_o,
  output logic [31:0]         core_angle_o,
  output logic [95:0]         core_qutrit_o,
  input  logic                core_valid_i,
  input  logic [95:0]         core_result_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [IDW-1:0]      rsp_id_o,
  output logic [95:0]         rsp_data_o,
  output logic                rsp_err_o,
  output logic                busy_o,
  output logic [31:0]         op_count_o
);

  localparam int unsigned SELW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned AXW  = 3;
  localparam int unsigned ANGW = 32;
  localparam int unsigned QW   = 96;
  localparam int unsigned CNTW = 32;
`ifdef TOWER_SU3_SCHED_TIMEOUT_EN
  localparam int unsigned WDW  = 16;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic              core_start_q, core_start_d;
  logic [AXW-1:0]    axis_q, axis_d;
  logic [ANGW-1:0]   angle_q, angle_d;
  logic [QW-1:0]     qutrit_q, qutrit_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [QW-1:0]     rsp_data_q, rsp_data_d;
  logic              busy_q, busy_d;
  logic [CNTW-1:0]   op_count_q, op_count_d;
  logic [NREQ-1:0]   grant_c;
`ifdef TOWER_SU3_SCHED_TIMEOUT_EN
  logic              rsp_err_q, rsp_err_d;
  logic [WDW-1:0]    wd_q, wd_d;
`endif

  // Round-robin search: rotate requests so the pointer sits at bit 0, take the lowest set bit
  logic [2*NREQ-1:0] gnt_dbl;
  logic [NREQ-1:0]   gnt_rot;
  logic              gnt_found;
  logic [SELW-1:0]   gnt_off;
  logic [SELW:0]     gnt_sum;
  logic [SELW-1:0]   gnt_idx;
  logic [NREQ-1:0]   gnt_oh;
  always_comb begin
    gnt_dbl   = {req_valid_i, req_valid_i} >> ptr_q;
    gnt_rot   = gnt_dbl[NREQ-1:0];
    gnt_found = |gnt_rot;
    gnt_off   = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (gnt_rot[i]) gnt_off = SELW'(i);
    end
    gnt_sum = {1'b0, ptr_q} + {1'b0, gnt_off};
    if (gnt_sum >= (SELW+1)'(NREQ)) gnt_idx = SELW'(gnt_sum - (SELW+1)'(NREQ));
    else                            gnt_idx = gnt_sum[SELW-1:0];
    gnt_oh = gnt_found ? (NREQ'(1) << gnt_idx) : '0;
  end

  // Operand mux for the granted requester
  logic [AXW-1:0]  sel_axis;
  logic [ANGW-1:0] sel_angle;
  logic [QW-1:0]   sel_qutrit;
  always_comb begin
    sel_axis   = '0;
    sel_angle  = '0;
    sel_qutrit = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt_oh[i]) begin
        sel_axis   = req_axis_i[AXW*i +: AXW];
        sel_angle  = req_angle_i[ANGW*i +: ANGW];
        sel_qutrit = req_qutrit_i[QW*i +: QW];
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    axis_d     = axis_q;
    angle_d    = angle_q;
    qutrit_d   = qutrit_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    op_count_d = op_count_q;
    grant_c    = '0;
`ifdef TOWER_SU3_SCHED_TIMEOUT_EN
    rsp_err_d  = rsp_err_q;
    wd_d       = wd_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          grant_c  = gnt_oh;
          axis_d   = sel_axis;
          angle_d  = sel_angle;
          qutrit_d = sel_qutrit;
          rsp_id_d = IDW'(gnt_idx);
          ptr_d    = (gnt_idx == SELW'(NREQ - 1)) ? '0 : gnt_idx + SELW'(1);
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef TOWER_SU3_SCHED_TIMEOUT_EN
        wd_d    = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_valid_i) begin
          rsp_data_d = core_result_i;
`ifdef TOWER_SU3_SCHED_TIMEOUT_EN
          rsp_err_d  = 1'b0;
`endif
          state_d    = S_RESP;
        end
`ifdef TOWER_SU3_SCHED_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          op_count_d = op_count_q + CNTW'(1);
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    core_start_d = (state_d == S_ISSUE);
    rsp_valid_d  = (state_d == S_RESP);
    busy_d       = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      core_start_q <= 1'b0;
      axis_q       <= '0;
      angle_q      <= '0;
      qutrit_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
      op_count_q   <= '0;
`ifdef TOWER_SU3_SCHED_TIMEOUT_EN
      rsp_err_q    <= 1'b0;
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      core_start_q <= core_start_d;
      axis_q       <= axis_d;
      angle_q      <= angle_d;
      qutrit_q     <= qutrit_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      busy_q       <= busy_d;
      op_count_q   <= op_count_d;
`ifdef TOWER_SU3_SCHED_TIMEOUT_EN
      rsp_err_q    <= rsp_err_d;
      wd_q         <= wd_d;
`endif
    end
  end

  // Accept is combinational so the grant lands in the same cycle; held low during reset
  assign req_ready_o   = rst_n ? grant_c : '0;
  assign core_start_o  = core_start_q;
  assign core_axis_o   = axis_q;
  assign core_angle_o  = angle_q;
  assign core_qutrit_o = qutrit_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_id_o      = rsp_id_q;
  assign rsp_data_o    = rsp_data_q;
  assign busy_o        = busy_q;
  assign op_count_o    = op_count_q;
`ifdef TOWER_SU3_SCHED_TIMEOUT_EN
  assign rsp_err_o     = rsp_err_q;
`else
  assign rsp_err_o     = 1'b0;
`endif

endmodule
